mdu_seq_ctrl: RTL and testbench

- Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU with a radix-2 shift-add / restoring-subtract engine over WIDTH cycles.
- Owns the HI/LO registers and stalls the pipeline while busy.
- Sits beside the single-cycle ALU. The main decoder drives start_i and op_i; hazard logic consumes stall_o.

---
 rtl/mdu_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_ctrl.sv
// Iterative MIPS multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, owning HI/LO and stalling the pipeline.
module mdu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            abs_mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            abs_mag = v;
        end
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [WIDTH-1:0]     acc_r, acc_s;
    logic [WIDTH-1:0]     q_r, q_s;
    logic [WIDTH-1:0]     b_r, b_s;
    logic                 is_div_r, is_div_s;
    logic                 sign_lo_r, sign_lo_s;
    logic                 sign_hi_r, sign_hi_s;
    logic                 dbz_r, dbz_s;
    logic [WIDTH-1:0]     hi_r, hi_s;
    logic [WIDTH-1:0]     lo_r, lo_s;

    logic                 is_signed_s;
    logic [WIDTH-1:0]     mag_rs_s, mag_rt_s;
    logic [WIDTH:0]       sum_s, shl_s, diff_s;
    logic [WIDTH-1:0]     iter_acc_s, iter_q_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     hi_res_s, lo_res_s;

    assign is_signed_s = ~op_i[0];
    assign mag_rs_s    = abs_mag(rs_data_i, is_signed_s);
    assign mag_rt_s    = abs_mag(rt_data_i, is_signed_s);

    // One engine step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        sum_s      = {1'b0, acc_r};
        shl_s      = {acc_r, q_r[WIDTH-1]};
        diff_s     = shl_s - {1'b0, b_r};
        iter_acc_s = acc_r;
        iter_q_s   = q_r;
        if (is_div_r) begin
            if (!diff_s[WIDTH]) begin
                iter_acc_s = diff_s[WIDTH-1:0];
                iter_q_s   = {q_r[WIDTH-2:0], 1'b1};
            end else begin
                iter_acc_s = shl_s[WIDTH-1:0];
                iter_q_s   = {q_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q_r[0]) begin
                sum_s = {1'b0, acc_r} + {1'b0, b_r};
            end else begin
                sum_s = {1'b0, acc_r};
            end
            iter_acc_s = sum_s[WIDTH:1];
            iter_q_s   = {sum_s[0], q_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the result produced by the final iteration.
    always_comb begin
        prod_s   = {iter_acc_s, iter_q_s};
        hi_res_s = iter_acc_s;
        lo_res_s = iter_q_s;
        if (is_div_r) begin
            if (sign_lo_r) begin
                lo_res_s = ~iter_q_s + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                lo_res_s = iter_q_s;
            end
            if (sign_hi_r) begin
                hi_res_s = ~iter_acc_s + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                hi_res_s = iter_acc_s;
            end
        end else begin
            if (sign_lo_r) begin
                prod_s = ~{iter_acc_s, iter_q_s} + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end else begin
                prod_s = {iter_acc_s, iter_q_s};
            end
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state and datapath-load logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        acc_s     = acc_r;
        q_s       = q_r;
        b_s       = b_r;
        is_div_s  = is_div_r;
        sign_lo_s = sign_lo_r;
        sign_hi_s = sign_hi_r;
        dbz_s     = dbz_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    cnt_s     = {CNT_W{1'b0}};
                    acc_s     = ZERO_W;
                    is_div_s  = op_i[1];
                    sign_lo_s = is_signed_s & (rs_data_i[WIDTH-1] ^ rt_data_i[WIDTH-1]);
                    sign_hi_s = is_signed_s & rs_data_i[WIDTH-1];
                    if (op_i[1]) begin
                        q_s = mag_rs_s;
                        b_s = mag_rt_s;
                    end else begin
                        q_s = mag_rt_s;
                        b_s = mag_rs_s;
                    end
                    if (op_i[1] && (rt_data_i == ZERO_W)) begin
                        dbz_s   = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        dbz_s   = 1'b0;
                        state_s = ST_CALC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_s = ST_IDLE;
                end else begin
                    acc_s = iter_acc_s;
                    q_s   = iter_q_s;
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        hi_s    = hi_res_s;
                        lo_s    = lo_res_s;
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, engine and HI/LO registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= ZERO_W;
            q_r       <= ZERO_W;
            b_r       <= ZERO_W;
            is_div_r  <= 1'b0;
            sign_lo_r <= 1'b0;
            sign_hi_r <= 1'b0;
            dbz_r     <= 1'b0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            acc_r     <= acc_s;
            q_r       <= q_s;
            b_r       <= b_s;
            is_div_r  <= is_div_s;
            sign_lo_r <= sign_lo_s;
            sign_hi_r <= sign_hi_s;
            dbz_r     <= dbz_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
        end
    end

    // stall_o must react in the issuing cycle, hence the combinational term.
    assign stall_o       = ((state_r == ST_IDLE) & start_i & ~flush_i) | (state_r == ST_CALC);
    assign busy_o        = (state_r == ST_CALC);
    assign done_o        = (state_r == ST_DONE);
    assign div_by_zero_o = (state_r == ST_DONE) & dbz_r;
    assign hi_o          = hi_r;
    assign lo_o          = lo_r;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed self-checking bench for mdu_seq_ctrl with hand-computed HI/LO results.
module tb_mdu_seq_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        flush = 1'b0;
    logic        stall, busy, done, dbz;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    mdu_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .rs_data_i(rs_data), .rt_data_i(rt_data), .flush_i(flush),
        .stall_o(stall), .busy_o(busy), .done_o(done), .div_by_zero_o(dbz),
        .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move into the next cycle, 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue in the current cycle T; returns in T+1 with garbage on the operand inputs.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        #1;
        chk("issue_stall_busy", {62'h0, stall, busy}, 64'h2);
        tick();
        start = 1'b0;
        op = o ^ 2'b11;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Full operation: T issue, T+1..T+32 busy, T+33 done with result, returns in T+34.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        start_op(o, a, b);
        for (int i = 1; i <= 32; i++) begin
            #1;
            chk({tag, "_calc_flags"}, {61'h0, stall, busy, done}, 64'h6);
            chk({tag, "_calc_hilo"}, {hi, lo}, {model_hi, model_lo});
            rs_data = $urandom;
            tick();
        end
        model_hi = eh;
        model_lo = el;
        #1;
        chk({tag, "_done_flags"}, {60'h0, stall, busy, done, dbz}, 64'h2);
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
        tick();
        #1;
        chk({tag, "_idle_flags"}, {61'h0, stall, busy, done}, 64'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_flags", {60'h0, stall, busy, done, dbz}, 64'h0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Multiply results
        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        tick();
        do_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        tick();
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
        tick();
        do_op("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        tick();

        // Signed divide, including the most negative dividend over -1
        do_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        tick();
        do_op("div_7_m2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        tick();
        do_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        tick();

        // Preload HI=0x11, LO=0x22 then divide by zero
        do_op("preload", OP_DIVU, 32'h00002211, 32'h00000100, 32'h00000011, 32'h00000022);
        tick();
        start_op(OP_DIV, 32'd5, 32'd0);
        #1;
        chk("dbz_done_flags", {60'h0, stall, busy, done, dbz}, 64'h3);
        chk("dbz_hilo", {hi, lo}, {32'h11, 32'h22});
        tick();
        #1;
        chk("dbz_after_flags", {60'h0, stall, busy, done, dbz}, 64'h0);
        chk("dbz_after_hilo", {hi, lo}, {32'h11, 32'h22});
        tick();

        // Flush at T+10, then restart in T+11
        start_op(OP_MULTU, 32'h00001234, 32'h00000010);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("flush10_busy", {63'h0, busy}, 64'h1);
        tick();
        flush = 1'b0;
        chk("flush10_idle_flags", {61'h0, stall, busy, done}, 64'h0);
        chk("flush10_hilo", {hi, lo}, {32'h11, 32'h22});
        do_op("restart_6x7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h0000002A);
        tick();

        // Flush on the last CALC cycle blocks the write
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (31) tick();
        flush = 1'b1;
        #1;
        chk("flushlast_busy", {63'h0, busy}, 64'h1);
        tick();
        flush = 1'b0;
        #1;
        chk("flushlast_flags", {60'h0, stall, busy, done, dbz}, 64'h0);
        chk("flushlast_hilo", {hi, lo}, {32'h0, 32'h2A});
        tick();
        #1;
        chk("flushlast_nodone", {63'h0, done}, 64'h0);

        // start and flush together in IDLE
        start = 1'b1; flush = 1'b1; op = OP_MULTU; rs_data = 32'd9; rt_data = 32'd9;
        #1;
        chk("startflush_stall", {63'h0, stall}, 64'h0);
        tick();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("startflush_flags", {61'h0, stall, busy, done}, 64'h0);
        tick();
        #1;
        chk("startflush_flags2", {61'h0, stall, busy, done}, 64'h0);
        chk("startflush_hilo", {hi, lo}, {32'h0, 32'h2A});
        tick();

        // Asynchronous reset mid-CALC
        start_op(OP_MULTU, 32'h0000FFFF, 32'h0000FFFF);
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {60'h0, stall, busy, done, dbz}, 64'h0);
        chk("async_rst_hilo", {hi, lo}, 64'h0);
        model_hi = 32'h0;
        model_lo = 32'h0;
        #1;
        rst_n = 1'b1;
        tick();
        #1;
        chk("post_rst_flags", {61'h0, stall, busy, done}, 64'h0);
        do_op("post_rst_2x3", OP_MULTU, 32'd2, 32'd3, 32'h0, 32'h00000006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
